// File: rtl/systolic_output_collector_pkg.sv
// rtl/systolic_output_collector_pkg.sv - shared timing and sizing constants for the PE array and its collector
package systolic_output_collector_pkg;
  localparam int WORDLENGTH = 16;
  localparam int NUM_PE = 8;
  localparam int SLOT_CYCLES = 30;
  localparam logic [4:0] SLOT_CNT_RESET = 5'd31;
  localparam int FIFO_DEPTH = 4;
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [2:0]            pe;
    logic [WORDLENGTH-1:0] word;
  } sample_t;
endpackage

// File: rtl/systolic_output_collector_if.sv
// rtl/systolic_output_collector_if.sv - valid/ready sample port toward the interpolated-sample consumer
interface systolic_output_collector_if
  import systolic_output_collector_pkg::*;
#(
  parameter int WL = WORDLENGTH
) ();
  logic [WL-1:0] out_word;
  logic [2:0]    out_pe;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_word, output out_pe, output out_valid, input out_ready);
  modport slave  (input out_word, input out_pe, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_output_collector_fifo.sv
// rtl/systolic_output_collector_fifo.sv - small synchronous FIFO with a registered head entry
module collector_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk30x,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign fill    = count;

  always_ff @(posedge clk30x) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/systolic_output_collector.sv
// rtl/systolic_output_collector.sv - captures each PE result at its window close and queues it for the consumer
module systolic_output_collector
  import systolic_output_collector_pkg::*;
(
  input  logic                           clk30x,
  input  logic                           reset,
  input  logic [NUM_PE*WORDLENGTH-1:0]   pe_words,
  systolic_output_collector_if.master    sample,
  output logic                           overflow,
  output logic [FILL_W-1:0]              fill
);
  localparam logic [4:0] SLOT_LAST = 5'(SLOT_CYCLES - 1);

  logic [4:0]            slot_cnt;
  logic [2:0]            word_idx;
  logic [2:0]            warmup;
  logic [2:0]            cap_pe;
  logic                  cap;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [WORDLENGTH-1:0] pe_arr [NUM_PE];
  sample_t               cap_entry;
  sample_t               head;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_unpack
    assign pe_arr[g] = pe_words[g*WORDLENGTH +: WORDLENGTH];
  end

  // Window of PE k closes at the end of the slot preceding word k, hence word_idx+1.
  assign cap       = (slot_cnt == SLOT_LAST);
  assign cap_pe    = word_idx + 3'd1;
  assign cap_entry = '{pe: cap_pe, word: pe_arr[cap_pe]};
  assign push      = cap && (warmup == 3'd7);
  assign pop       = sample.out_valid && sample.out_ready;

  always_ff @(posedge clk30x) begin
    if (reset) begin
      slot_cnt <= SLOT_CNT_RESET;
      word_idx <= '0;
      warmup   <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap) begin
        slot_cnt <= '0;
        word_idx <= word_idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + 5'd1;
      end
      if (cap && warmup != 3'd7) warmup <= warmup + 3'd1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  collector_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk30x (clk30x),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (cap_entry),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .fill   (fill)
  );

  assign sample.out_valid = !empty;
  assign sample.out_word  = head.word;
  assign sample.out_pe    = head.pe;
endmodule

// File: tb/tb_systolic_output_collector.sv
// tb/tb_systolic_output_collector.sv - scoreboard bench for the systolic output collector
module tb_systolic_output_collector;
  import systolic_output_collector_pkg::*;

  typedef struct {
    logic [2:0]  pe;
    logic [15:0] word;
  } exp_t;

  logic                         clk30x = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_PE*WORDLENGTH-1:0] pe_words = '0;
  logic                         overflow;
  logic [FILL_W-1:0]            fill;
  exp_t                         sb[$];
  int                           n_checks = 0;
  int                           n_fail = 0;
  int                           cur = 0;

  systolic_output_collector_if bus ();

  systolic_output_collector dut (
    .clk30x   (clk30x),
    .reset    (reset),
    .pe_words (pe_words),
    .sample   (bus.master),
    .overflow (overflow),
    .fill     (fill)
  );

  always #5 clk30x = ~clk30x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_pe(input int k, input logic [15:0] v);
    pe_words[k*16 +: 16] = v;
  endtask

  task automatic set_all(input logic [15:0] base, input logic add_k);
    for (int k = 0; k < NUM_PE; k++) set_pe(k, add_k ? base + 16'(k) : base);
  endtask

  task automatic expect_sample(input int k, input logic [15:0] w);
    exp_t e;
    e.pe = 3'(k);
    e.word = w;
    sb.push_back(e);
  endtask

  // Cycle 0 is the first cycle with reset low; captures land at cycles 30*n.
  task automatic to_cycle(input int c);
    while (cur < c) begin
      @(negedge clk30x);
      cur++;
    end
  endtask

  task automatic do_reset(input logic check_drained);
    if (check_drained) chk("sb_drained", sb.size(), 0);
    @(negedge clk30x);
    reset = 1'b1;
    repeat (2) @(negedge clk30x);
    reset = 1'b0;
    sb.delete();
    cur = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk30x);
      #1;
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected: got pe %0d word %h expected nothing", bus.out_pe, bus.out_word);
        end else begin
          e = sb.pop_front();
          chk("mon_pe", 32'(bus.out_pe), 32'(e.pe));
          chk("mon_word", 32'(bus.out_word), 32'(e.word));
        end
      end
    end
  end

  initial begin : stim
    bus.out_ready = 1'b1;

    // 1: steady stream after warm-up
    set_all(16'h1000, 1'b1);
    do_reset(1'b0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_word", 32'(bus.out_word), 0);
    chk("rst_pe", 32'(bus.out_pe), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_fill", 32'(fill), 0);
    to_cycle(211);
    chk("t1_warmup_quiet", 32'(bus.out_valid), 0);
    for (int n = 8; n <= 16; n++) begin
      to_cycle(30*n);
      chk("t1_pre_cap_valid", 32'(bus.out_valid), 0);
      expect_sample(n % 8, 16'h1000 + 16'(n % 8));
      to_cycle(30*n + 1);
      chk("t1_latency", 32'(bus.out_valid), 1);
    end
    to_cycle(30*16 + 3);
    chk("t1_fill_end", 32'(fill), 0);

    // 2: stall from start, overflow on fifth capture
    bus.out_ready = 1'b0;
    do_reset(1'b1);
    for (int n = 8; n <= 11; n++) begin
      to_cycle(30*n);
      expect_sample(n % 8, 16'h1000 + 16'(n % 8));
      to_cycle(30*n + 1);
      chk("t2_fill_rise", 32'(fill), 32'(n - 7));
      chk("t2_no_ovf", 32'(overflow), 0);
    end
    to_cycle(361);
    chk("t2_ovf_set", 32'(overflow), 1);
    chk("t2_fill_hold", 32'(fill), 4);
    chk("t2_head_pe", 32'(bus.out_pe), 0);
    chk("t2_head_word", 32'(bus.out_word), 32'h1000);
    to_cycle(362);
    bus.out_ready = 1'b1;
    to_cycle(370);
    chk("t2_sticky", 32'(overflow), 1);
    chk("t2_drained", 32'(fill), 0);

    // 3: full queue, pop coincides with push
    bus.out_ready = 1'b0;
    do_reset(1'b1);
    for (int n = 8; n <= 11; n++) begin
      to_cycle(30*n);
      expect_sample(n % 8, 16'h1000 + 16'(n % 8));
    end
    to_cycle(360);
    bus.out_ready = 1'b1;
    expect_sample(4, 16'h1004);
    to_cycle(361);
    bus.out_ready = 1'b0;
    chk("t3_fill", 32'(fill), 4);
    chk("t3_no_ovf", 32'(overflow), 0);
    chk("t3_head_pe", 32'(bus.out_pe), 1);
    to_cycle(362);
    bus.out_ready = 1'b1;
    to_cycle(370);
    chk("t3_drained", 32'(fill), 0);

    // 4: stall three slots then drain back-to-back
    bus.out_ready = 1'b0;
    set_all(16'hA5C0, 1'b1);
    set_pe(1, 16'h7FFF);
    set_pe(2, 16'h8001);
    do_reset(1'b1);
    to_cycle(240); expect_sample(0, 16'hA5C0);
    to_cycle(270); expect_sample(1, 16'h7FFF);
    to_cycle(300); expect_sample(2, 16'h8001);
    to_cycle(305);
    chk("t4_fill3", 32'(fill), 3);
    bus.out_ready = 1'b1;
    to_cycle(306); chk("t4_fill2", 32'(fill), 2);
    to_cycle(307); chk("t4_fill1", 32'(fill), 1);
    to_cycle(308);
    chk("t4_valid_fall", 32'(bus.out_valid), 0);
    chk("t4_fill0", 32'(fill), 0);

    // 5: mid-slot reset flushes queue and overflow
    bus.out_ready = 1'b0;
    set_all(16'h1000, 1'b1);
    do_reset(1'b1);
    for (int n = 8; n <= 11; n++) begin
      to_cycle(30*n);
      expect_sample(n % 8, 16'h1000 + 16'(n % 8));
    end
    to_cycle(365);
    bus.out_ready = 1'b1;
    to_cycle(367);
    bus.out_ready = 1'b0;
    chk("t5_pre_fill", 32'(fill), 2);
    chk("t5_pre_ovf", 32'(overflow), 1);
    to_cycle(375);
    reset = 1'b1;
    @(negedge clk30x);
    reset = 1'b0;
    sb.delete();
    cur = 0;
    chk("t5_valid", 32'(bus.out_valid), 0);
    chk("t5_fill", 32'(fill), 0);
    chk("t5_ovf", 32'(overflow), 0);
    bus.out_ready = 1'b1;
    to_cycle(240);
    chk("t5_rewarm", 32'(bus.out_valid), 0);
    expect_sample(0, 16'h1000);
    to_cycle(245);

    // 6: only the cap-cycle value of pe_words is captured
    set_all(16'h5555, 1'b0);
    do_reset(1'b1);
    to_cycle(240); set_pe(0, 16'hBEEF); expect_sample(0, 16'hBEEF);
    to_cycle(241); set_pe(0, 16'h5555);
    to_cycle(250); set_pe(2, 16'h1234);
    to_cycle(251); set_pe(2, 16'h5555);
    to_cycle(269); set_pe(1, 16'h4321);
    to_cycle(270); set_pe(1, 16'hBEEF); expect_sample(1, 16'hBEEF);
    to_cycle(271); set_pe(1, 16'h5555);
    to_cycle(300); expect_sample(2, 16'h5555);
    to_cycle(305);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
